// File: rtl/opc_acc_cpu_p_if.sv
// Memory bus between the accumulator core and the tile's external memory port.
// The core drives the request side, and ready completes one access.
interface opc_acc_cpu_p_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 11
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic          mem_valid;
  logic          mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_valid,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_valid,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/opc_acc_cpu_p.sv
// Parametrised two-word-instruction accumulator CPU with a valid/ready memory bus
// and a circular hardware return stack.
module opc_acc_cpu_p #(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 11,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 'h100
) (
  input  logic            clk,
  input  logic            rst_n,
  opc_acc_cpu_p_if.master bus,
  output logic            halted,
  output logic            stack_err,
  output logic [DW-1:0]   acc_dbg,
  output logic            carry_dbg
);
  localparam int unsigned OW  = 5;
  localparam int unsigned HW  = AW - DW;
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PW  = $clog2(STACK_DEPTH);

  localparam logic [OW-1:0] OP_AND_M = 5'b00000;
  localparam logic [OW-1:0] OP_LDA_M = 5'b00001;
  localparam logic [OW-1:0] OP_NOT_M = 5'b00010;
  localparam logic [OW-1:0] OP_ADD_M = 5'b00011;
  localparam logic [OW-1:0] OP_STAP  = 5'b01000;
  localparam logic [OW-1:0] OP_LDAP  = 5'b01001;
  localparam logic [OW-1:0] OP_AND_I = 5'b10000;
  localparam logic [OW-1:0] OP_LDA_I = 5'b10001;
  localparam logic [OW-1:0] OP_NOT_I = 5'b10010;
  localparam logic [OW-1:0] OP_ADD_I = 5'b10011;
  localparam logic [OW-1:0] OP_STA   = 5'b11000;
  localparam logic [OW-1:0] OP_JPC   = 5'b11001;
  localparam logic [OW-1:0] OP_JPZ   = 5'b11010;
  localparam logic [OW-1:0] OP_JP    = 5'b11011;
  localparam logic [OW-1:0] OP_JSR   = 5'b11100;
  localparam logic [OW-1:0] OP_RTS   = 5'b11101;
  localparam logic [OW-1:0] OP_CLC   = 5'b11110;
  localparam logic [OW-1:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_RDMEM,
    S_RDMEM2,
    S_EXEC,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [OW-1:0]    opc_q, opc_d;
  logic [HW-1:0]    hi_q, hi_d;
  logic [DW-1:0]    w1_q, w1_d;
  logic [DW-1:0]    opr_q, opr_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [AW-1:0]    stack_q [STACK_DEPTH];

  logic [AW-1:0]    opaddr;
  logic [AW-1:0]    ptraddr;
  logic [DW-1:0]    operand;
  logic [DW:0]      sum;
  logic [PW-1:0]    wp_inc;
  logic [PW-1:0]    wp_dec;
  logic [AW-1:0]    addr_c;
  logic             valid_c;
  logic             we_c;
  logic             push_c;

  assign opaddr  = {hi_q, w1_q};
  assign ptraddr = AW'(opr_q);
  assign operand = opc_q[OW-1] ? w1_q : opr_q;
  assign sum     = {1'b0, acc_q} + {1'b0, operand} + {{DW{1'b0}}, carry_q};
  assign wp_inc  = (wp_q == PW'(STACK_DEPTH - 1)) ? '0 : wp_q + PW'(1);
  assign wp_dec  = (wp_q == '0) ? PW'(STACK_DEPTH - 1) : wp_q - PW'(1);

  // Request strobes follow the state but are killed at once by reset.
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = acc_q;
  assign bus.mem_valid = valid_c & rst_n;
  assign bus.mem_we    = we_c & rst_n;

  assign halted    = halted_q;
  assign stack_err = err_q;
  assign acc_dbg   = acc_q;
  assign carry_dbg = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH0;
      pc_q     <= AW'(RESET_PC);
      opc_q    <= '0;
      hi_q     <= '0;
      w1_q     <= '0;
      opr_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      sp_q     <= '0;
      wp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opc_q    <= opc_d;
      hi_q     <= hi_d;
      w1_q     <= w1_d;
      opr_q    <= opr_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      sp_q     <= sp_d;
      wp_q     <= wp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Return-stack storage; on overflow the write pointer wraps over the oldest entry.
  always_ff @(posedge clk) begin
    if (push_c) begin
      stack_q[wp_q] <= pc_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opc_d    = opc_q;
    hi_d     = hi_q;
    w1_d     = w1_q;
    opr_d    = opr_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    sp_d     = sp_q;
    wp_d     = wp_q;
    halted_d = halted_q;
    err_d    = err_q;
    addr_c   = pc_q;
    valid_c  = 1'b0;
    we_c     = 1'b0;
    push_c   = 1'b0;

    case (state_q)
      S_FETCH0: begin
        valid_c = 1'b1;
        if (bus.mem_ready) begin
          opc_d   = bus.mem_rdata[DW-1 -: OW];
          hi_d    = bus.mem_rdata[HW-1:0];
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH1;
        end
      end
      S_FETCH1: begin
        valid_c = 1'b1;
        if (bus.mem_ready) begin
          w1_d    = bus.mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = opc_q[OW-1] ? S_EXEC : S_RDMEM;
        end
      end
      S_RDMEM: begin
        valid_c = 1'b1;
        addr_c  = opaddr;
        if (bus.mem_ready) begin
          opr_d   = bus.mem_rdata;
          state_d = (opc_q == OP_LDAP) ? S_RDMEM2 : S_EXEC;
        end
      end
      S_RDMEM2: begin
        valid_c = 1'b1;
        addr_c  = ptraddr;
        if (bus.mem_ready) begin
          opr_d   = bus.mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH0;
        case (opc_q)
          OP_AND_M, OP_AND_I: begin
            acc_d   = acc_q & operand;
            carry_d = 1'b0;
          end
          OP_LDA_M, OP_LDA_I, OP_LDAP: acc_d = operand;
          OP_NOT_M, OP_NOT_I:          acc_d = ~operand;
          OP_ADD_M, OP_ADD_I:          {carry_d, acc_d} = sum;
          OP_STA, OP_STAP: begin
            valid_c = 1'b1;
            we_c    = 1'b1;
            addr_c  = (opc_q == OP_STA) ? opaddr : ptraddr;
            if (!bus.mem_ready) begin
              state_d = S_EXEC;
            end
          end
          OP_JPC: if (carry_q) pc_d = opaddr;
          OP_JPZ: if (acc_q == '0) pc_d = opaddr;
          OP_JP:  pc_d = opaddr;
          OP_JSR: begin
            push_c = 1'b1;
            pc_d   = opaddr;
            wp_d   = wp_inc;
            if (sp_q == SPW'(STACK_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              sp_d = sp_q + SPW'(1);
            end
          end
          OP_RTS: begin
            if (sp_q == '0) begin
              pc_d  = AW'(RESET_PC);
              err_d = 1'b1;
            end else begin
              pc_d = stack_q[wp_dec];
              wp_d = wp_dec;
              sp_d = sp_q - SPW'(1);
            end
          end
          OP_CLC: carry_d = 1'b0;
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH0;
    endcase
  end
endmodule
